// File: rtl/decode_ctrl_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master drives instructions and consumes control; slave is the stage.
interface decode_ctrl_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_funct3;
   logic            out_reg_write;
   logic            out_alu_src;
   logic            out_mem_write;
   logic            out_branch;
   logic            out_jump;
   logic            out_jalr;
   logic [2:0]      out_imm_src;
   logic [1:0]      out_result_src;
   logic [1:0]      out_alu_op;
   logic [1:0]      out_alu_a_src;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_rd,
      input  out_rs1, out_rs2, out_funct3,
      input  out_reg_write, out_alu_src, out_mem_write,
      input  out_branch, out_jump, out_jalr,
      input  out_imm_src, out_result_src,
      input  out_alu_op, out_alu_a_src, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_rd,
      output out_rs1, out_rs2, out_funct3,
      output out_reg_write, out_alu_src, out_mem_write,
      output out_branch, out_jump, out_jalr,
      output out_imm_src, out_result_src,
      output out_alu_op, out_alu_a_src, out_illegal
   );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) registered decode stage with valid/ready flow,
// illegal flagging, EBREAK halt/drain FSM and saturating issue counter.
module decode_ctrl_stage #(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             resume,
   output logic             halted,
   output logic [CNT_W-1:0] issue_count,
   decode_ctrl_stage_if.slave bus
);
   typedef enum logic [1:0] {
      RUN, HALT_PEND, HALTED
   } state_t;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic [2:0] imm_src;
      logic [1:0] result_src;
      logic [1:0] alu_op;
      logic [1:0] alu_a_src;
      logic       illegal;
   } ctrl_t;

   localparam logic EN_M = (ENABLE_M != 0);

   state_t          state;
   ctrl_t           dec, ctrl_q;
   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [4:0]      rd_q, rs1_q, rs2_q;
   logic [2:0]      f3_q;

   logic [6:0] opc;
   logic       is_ebreak, xfer, muldiv;
   logic       op_r, op_imm, op_ld, op_st;
   logic       op_br, op_lui, op_aui, op_jal, op_jalr;

   assign opc       = bus.in_instr[6:0];
   assign is_ebreak = bus.in_instr == 32'h0010_0073;
   assign muldiv    = bus.in_instr[31:25] == 7'b0000001;

   assign op_r    = opc == 7'b0110011;
   assign op_imm  = opc == 7'b0010011;
   assign op_ld   = opc == 7'b0000011;
   assign op_st   = opc == 7'b0100011;
   assign op_br   = opc == 7'b1100011;
   assign op_lui  = opc == 7'b0110111;
   assign op_aui  = opc == 7'b0010111;
   assign op_jal  = opc == 7'b1101111;
   assign op_jalr = opc == 7'b1100111;

   assign bus.in_ready = (state == RUN) && !flush
                         && (!valid_q || bus.out_ready);
   assign xfer = bus.in_valid && bus.in_ready;

   // Illegal words leave every strobe low so they cannot write state.
   always_comb begin
      dec = '0;
      unique case (1'b1)
         op_r: begin
            if (muldiv && !EN_M) begin
               dec.illegal = 1'b1;
            end else begin
               dec.reg_write = 1'b1;
               dec.alu_op    = muldiv ? 2'b11 : 2'b10;
            end
         end
         op_imm: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = 2'b10;
         end
         op_ld: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = 2'b01;
         end
         op_st: begin
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
            dec.imm_src   = 3'b001;
         end
         op_br: begin
            dec.branch  = 1'b1;
            dec.alu_op  = 2'b01;
            dec.imm_src = 3'b010;
         end
         op_lui: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = 3'b011;
            dec.alu_a_src = 2'b10;
         end
         op_aui: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = 3'b011;
            dec.alu_a_src = 2'b01;
         end
         op_jal: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.result_src = 2'b10;
            dec.imm_src    = 3'b100;
         end
         op_jalr: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.jump       = 1'b1;
            dec.jalr       = 1'b1;
            dec.result_src = 2'b10;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         halted      <= 1'b0;
         valid_q     <= 1'b0;
         ctrl_q      <= '0;
         pc_q        <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         f3_q        <= '0;
         issue_count <= '0;
      end else begin
         // An accepted EBREAK is swallowed, so it only drains the slot.
         if (flush) begin
            valid_q <= 1'b0;
         end else if (xfer && !is_ebreak) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec;
            pc_q    <= bus.in_pc;
            rd_q    <= bus.in_instr[11:7];
            rs1_q   <= bus.in_instr[19:15];
            rs2_q   <= bus.in_instr[24:20];
            f3_q    <= bus.in_instr[14:12];
         end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
         end

         if (valid_q && bus.out_ready && issue_count != '1)
            issue_count <= issue_count + CNT_W'(1);

         unique case (state)
            RUN: begin
               if (xfer && is_ebreak)
                  state <= HALT_PEND;
            end
            HALT_PEND: begin
               if (!valid_q) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            HALTED: begin
               if (resume) begin
                  state  <= RUN;
                  halted <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.out_valid      = valid_q;
   assign bus.out_pc         = pc_q;
   assign bus.out_rd         = rd_q;
   assign bus.out_rs1        = rs1_q;
   assign bus.out_rs2        = rs2_q;
   assign bus.out_funct3     = f3_q;
   assign bus.out_reg_write  = ctrl_q.reg_write;
   assign bus.out_alu_src    = ctrl_q.alu_src;
   assign bus.out_mem_write  = ctrl_q.mem_write;
   assign bus.out_branch     = ctrl_q.branch;
   assign bus.out_jump       = ctrl_q.jump;
   assign bus.out_jalr       = ctrl_q.jalr;
   assign bus.out_imm_src    = ctrl_q.imm_src;
   assign bus.out_result_src = ctrl_q.result_src;
   assign bus.out_alu_op     = ctrl_q.alu_op;
   assign bus.out_alu_a_src  = ctrl_q.alu_a_src;
   assign bus.out_illegal    = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench: decode table plus hold, EBREAK, flush,
// counter saturation and async reset sequences.
module tb_decode_ctrl_stage;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic resume;
   logic halted, halted_nm, halted_sat;
   logic [15:0] cnt;
   logic [15:0] cnt_nm;
   logic [3:0]  cnt_sat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_ctrl_stage_if #(.XLEN(XLEN)) bus ();
   decode_ctrl_stage_if #(.XLEN(XLEN)) bus_nm ();
   decode_ctrl_stage_if #(.XLEN(XLEN)) bus_sat ();

   assign bus_nm.in_valid   = bus.in_valid;
   assign bus_nm.in_instr   = bus.in_instr;
   assign bus_nm.in_pc      = bus.in_pc;
   assign bus_nm.out_ready  = bus.out_ready;
   assign bus_sat.in_valid  = bus.in_valid;
   assign bus_sat.in_instr  = bus.in_instr;
   assign bus_sat.in_pc     = bus.in_pc;
   assign bus_sat.out_ready = bus.out_ready;

   decode_ctrl_stage #(
      .XLEN(XLEN), .ENABLE_M(1), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .resume(resume), .halted(halted),
      .issue_count(cnt), .bus(bus)
   );

   decode_ctrl_stage #(
      .XLEN(XLEN), .ENABLE_M(0), .CNT_W(16)
   ) dut_nm (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .resume(resume), .halted(halted_nm),
      .issue_count(cnt_nm), .bus(bus_nm)
   );

   decode_ctrl_stage #(
      .XLEN(XLEN), .ENABLE_M(1), .CNT_W(4)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .resume(resume), .halted(halted_sat),
      .issue_count(cnt_sat), .bus(bus_sat)
   );

   logic [15:0] ctrl_m, ctrl_nm;
   logic [17:0] flds;

   assign ctrl_m = {bus.out_reg_write, bus.out_alu_src,
                    bus.out_mem_write, bus.out_branch,
                    bus.out_jump, bus.out_jalr,
                    bus.out_imm_src, bus.out_result_src,
                    bus.out_alu_op, bus.out_alu_a_src,
                    bus.out_illegal};
   assign ctrl_nm = {bus_nm.out_reg_write, bus_nm.out_alu_src,
                     bus_nm.out_mem_write, bus_nm.out_branch,
                     bus_nm.out_jump, bus_nm.out_jalr,
                     bus_nm.out_imm_src, bus_nm.out_result_src,
                     bus_nm.out_alu_op, bus_nm.out_alu_a_src,
                     bus_nm.out_illegal};
   assign flds = {bus.out_rd, bus.out_rs1,
                  bus.out_rs2, bus.out_funct3};

   typedef struct {
      logic [31:0] instr;
      logic [15:0] ctrl;
      bit          m;
   } vec_t;

   vec_t vt[13];

   function automatic logic [15:0] cw(
      bit rw, bit as, bit mw, bit br, bit j, bit jr,
      logic [2:0] imm, logic [1:0] rs,
      logic [1:0] aop, logic [1:0] asrc, bit ill
   );
      return {rw, as, mw, br, j, jr, imm, rs, aop, asrc, ill};
   endfunction

   function automatic logic [17:0] fexp(logic [31:0] w);
      return {w[11:7], w[19:15], w[24:20], w[14:12]};
   endfunction

   task automatic chk(string name, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] ADD   = 32'h002081B3;
   localparam logic [31:0] LW    = 32'h0000A183;
   localparam logic [31:0] SW    = 32'h0020A423;
   localparam logic [31:0] SUB   = 32'h403100B3;
   localparam logic [31:0] EBRK  = 32'h00100073;

   logic [15:0] ill, c_add, c_lw, c_sw;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      ill   = cw(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,1);
      c_add = cw(1,0,0,0,0,0,3'b000,2'b00,2'b10,2'b00,0);
      c_lw  = cw(1,1,0,0,0,0,3'b000,2'b01,2'b00,2'b00,0);
      c_sw  = cw(0,1,1,0,0,0,3'b001,2'b00,2'b00,2'b00,0);
      vt[0]  = '{ADD, c_add, 0};
      vt[1]  = '{32'hFFF30293,
                 cw(1,1,0,0,0,0,3'b000,2'b00,2'b10,2'b00,0), 0};
      vt[2]  = '{LW, c_lw, 0};
      vt[3]  = '{SW, c_sw, 0};
      vt[4]  = '{32'h00208063,
                 cw(0,0,0,1,0,0,3'b010,2'b00,2'b01,2'b00,0), 0};
      vt[5]  = '{32'h123453B7,
                 cw(1,1,0,0,0,0,3'b011,2'b00,2'b00,2'b10,0), 0};
      vt[6]  = '{32'h00001097,
                 cw(1,1,0,0,0,0,3'b011,2'b00,2'b00,2'b01,0), 0};
      vt[7]  = '{32'h000000EF,
                 cw(1,0,0,0,1,0,3'b100,2'b10,2'b00,2'b00,0), 0};
      vt[8]  = '{32'h000100E7,
                 cw(1,1,0,0,1,1,3'b000,2'b10,2'b00,2'b00,0), 0};
      vt[9]  = '{32'h027302B3,
                 cw(1,0,0,0,0,0,3'b000,2'b00,2'b11,2'b00,0), 1};
      vt[10] = '{32'h0000007F, ill, 0};
      vt[11] = '{32'h00000073, ill, 0};
      vt[12] = '{SUB, c_add, 0};

      rst_n         = 1'b0;
      flush         = 1'b0;
      resume        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b0;

      #2;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_count", 32'(cnt), 0);
      chk("rst_ctrl", 32'(ctrl_m), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 1);

      // back-to-back decode table, out_ready held high
      for (int i = 0; i < 13; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_instr  = vt[i].instr;
         bus.in_pc     = 32'h1000 + 32'(4 * i);
         bus.out_ready = 1'b1;
         tick();
         chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 1);
         chk($sformatf("v%0d_ctrl", i), 32'(ctrl_m),
             32'(vt[i].ctrl));
         chk($sformatf("v%0d_fields", i), 32'(flds),
             32'(fexp(vt[i].instr)));
         chk($sformatf("v%0d_pc", i), bus.out_pc,
             32'h1000 + 32'(4 * i));
         chk($sformatf("v%0d_count", i), 32'(cnt), 32'(i));
         chk($sformatf("v%0d_ctrl_nm", i), 32'(ctrl_nm),
             32'(vt[i].m ? ill : vt[i].ctrl));
      end
      bus.in_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(bus.out_valid), 0);
      chk("drain_count", 32'(cnt), 13);

      // lw held for 3 cycles while sw waits
      bus.in_valid  = 1'b1;
      bus.in_instr  = LW;
      bus.in_pc     = 32'h2000;
      bus.out_ready = 1'b0;
      tick();
      bus.in_instr = SW;
      bus.in_pc    = 32'h2004;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("hold_in_ready", 32'(bus.in_ready), 0);
         tick();
         chk("hold_valid", 32'(bus.out_valid), 1);
         chk("hold_ctrl", 32'(ctrl_m), 32'(c_lw));
         chk("hold_fields", 32'(flds), 32'(fexp(LW)));
         chk("hold_pc", bus.out_pc, 32'h2000);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("sw_in_ready", 32'(bus.in_ready), 1);
      tick();
      chk("sw_valid", 32'(bus.out_valid), 1);
      chk("sw_ctrl", 32'(ctrl_m), 32'(c_sw));
      chk("sw_pc", bus.out_pc, 32'h2004);
      chk("sw_count", 32'(cnt), 14);
      bus.in_valid = 1'b0;
      tick();
      chk("sw_drain_count", 32'(cnt), 15);
      chk("sat_count_15", 32'(cnt_sat), 15);

      // ebreak waits behind a held entry, then halts
      bus.in_valid  = 1'b1;
      bus.in_instr  = ADD;
      bus.in_pc     = 32'h3000;
      bus.out_ready = 1'b0;
      tick();
      bus.in_instr = EBRK;
      bus.in_pc    = 32'h3004;
      #1;
      chk("ebrk_blocked", 32'(bus.in_ready), 0);
      tick();
      chk("ebrk_held_pc", bus.out_pc, 32'h3000);
      chk("ebrk_held_valid", 32'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      #1;
      chk("ebrk_in_ready", 32'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("pend_valid", 32'(bus.out_valid), 0);
      chk("pend_in_ready", 32'(bus.in_ready), 0);
      chk("pend_halted", 32'(halted), 0);
      tick();
      chk("halt_halted", 32'(halted), 1);
      chk("halt_in_ready", 32'(bus.in_ready), 0);
      tick();
      chk("halt_stay", 32'(halted), 1);
      chk("halt_no_bundle", 32'(bus.out_valid), 0);
      chk("halt_count", 32'(cnt), 16);
      chk("sat_stays_15", 32'(cnt_sat), 15);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halted", 32'(halted), 0);
      chk("resume_in_ready", 32'(bus.in_ready), 1);

      // flush kills the held entry and the incoming word
      bus.in_valid  = 1'b1;
      bus.in_instr  = ADD;
      bus.in_pc     = 32'h4000;
      bus.out_ready = 1'b0;
      tick();
      chk("fl_pre_valid", 32'(bus.out_valid), 1);
      bus.in_instr = SUB;
      bus.in_pc    = 32'h4004;
      flush        = 1'b1;
      #1;
      chk("fl_in_ready", 32'(bus.in_ready), 0);
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_valid", 32'(bus.out_valid), 0);
      chk("fl_count", 32'(cnt), 16);
      tick();
      chk("fl_still_empty", 32'(bus.out_valid), 0);

      // one more issue past saturation
      bus.in_valid  = 1'b1;
      bus.in_instr  = ADD;
      bus.in_pc     = 32'h5000;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("post_count", 32'(cnt), 17);
      chk("sat_after_issue", 32'(cnt_sat), 15);

      // async reset in the middle of a transfer
      bus.in_valid = 1'b1;
      bus.in_instr = ADD;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 0);
      chk("arst_count", 32'(cnt), 0);
      chk("arst_sat_count", 32'(cnt_sat), 0);
      chk("arst_halted", 32'(halted), 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_in_ready", 32'(bus.in_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
